dmem_access_ctrl: RTL and testbench

//  Sequences MEM-stage data-memory accesses for the EX/MEM pipeline register outputs. Decodes

---
 rtl/dmem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//   Runs MEM-stage data-memory accesses for the EX/MEM pipeline register
//   outputs. It decodes load/store from M_op/M_funct3 and drives a
//   variable-latency memory through a req/ready handshake. The pipeline is
//   stalled until the access completes. Load results are returned sign- or
//   zero-extended. Misaligned accesses and memory timeouts raise flags.
//
// Parameters
//   TIMEOUT_CYCLES : maximum BUSY cycles without mem_ready before the access
//                    is aborted (0 = never time out)
//   CNT_W          : width of the wait counter; must be able to hold TIMEOUT_CYCLES
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous active-high reset
//   M_valid      in   1   MEM-stage instruction valid
//   M_op         in   7   opcode (load 0000011, store 0100011)
//   M_funct3     in   3   access size/sign
//   M_alu_out    in   32  effective byte address
//   M_dm_data    in   32  store data, right-aligned
//   stall        out  1   hold IF..MEM pipeline registers
//   load_data    out  32  extended load result, qualified by load_valid
//   load_valid   out  1   one-cycle pulse: load result available
//   misalign     out  1   one-cycle pulse: misaligned access suppressed
//   timeout      out  1   one-cycle pulse: access aborted by the wait limit
//   mem_req      out  1   memory request, held until mem_ready
//   mem_we       out  1   1 = write, 0 = read
//   mem_addr     out  32  word-aligned address
//   mem_wstrb    out  4   byte write strobes (0 on reads)
//   mem_wdata    out  32  lane-replicated store data
//   mem_ready    in   1   memory completes the request this cycle
//   mem_rdata    in   32  read word, valid with mem_ready on reads
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_valid,
  input  logic [6:0]  M_op,
  input  logic [2:0]  M_funct3,
  input  logic [31:0] M_alu_out,
  input  logic [31:0] M_dm_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_load;
  logic             r_misal;
  logic             r_tmo;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [31:0]      r_load_data;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [3:0]       r_mem_wstrb;
  logic [31:0]      r_mem_wdata;

  // ---------------------------------------------------------------------------
  // Request decode from the M_* inputs (only used while IDLE)
  // ---------------------------------------------------------------------------
  logic        w_is_load;
  logic        w_is_store;
  logic        w_access;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misalign;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign w_is_load  = (M_op == OP_LOAD);
  assign w_is_store = (M_op == OP_STORE);
  assign w_access   = M_valid & (w_is_load | w_is_store);

  // Size comes from funct3[1:0]; codes 10 and 11 both behave as a word,
  // which also covers every undefined funct3 encoding.
  assign w_is_byte = (M_funct3[1:0] == 2'b00);
  assign w_is_half = (M_funct3[1:0] == 2'b01);
  assign w_is_word = ~w_is_byte & ~w_is_half;

  assign w_misalign = (w_is_half & M_alu_out[0]) |
                      (w_is_word & (M_alu_out[1:0] != 2'b00));

  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = M_dm_data;
    if (w_is_byte) begin
      w_wdata = {4{M_dm_data[7:0]}};
    end else if (w_is_half) begin
      w_wdata = {2{M_dm_data[15:0]}};
    end
    if (w_is_store) begin
      if (w_is_byte) begin
        w_wstrb = 4'b0001 << M_alu_out[1:0];
      end else if (w_is_half) begin
        w_wstrb = 4'b0011 << M_alu_out[1:0];
      end else begin
        w_wstrb = 4'b1111;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane selection and extension, using the request captured in IDLE
  // ---------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr_lo)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // Abort on the last allowed BUSY cycle; a simultaneous mem_ready wins.
  logic w_tmo_hit;
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ready;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_load   <= 1'b0;
      r_misal     <= 1'b0;
      r_tmo       <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_load_data <= 32'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_access) begin
            r_is_load <= w_is_load;
            r_tmo     <= 1'b0;
            if (w_misalign) begin
              // Suppressed access: report in DONE without touching memory.
              r_state     <= S_DONE;
              r_misal     <= 1'b1;
              r_load_data <= 32'd0;
            end else begin
              r_state     <= S_BUSY;
              r_misal     <= 1'b0;
              r_funct3    <= M_funct3;
              r_addr_lo   <= M_alu_out[1:0];
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {M_alu_out[31:2], 2'b00};
              r_mem_wstrb <= w_wstrb;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            r_state <= S_DONE;
            if (!r_mem_we) begin
              r_load_data <= w_load_ext;
            end
          end else if (w_tmo_hit) begin
            r_state     <= S_DONE;
            r_tmo       <= 1'b1;
            r_load_data <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_misal <= 1'b0;
          r_tmo   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stall      = w_access & (r_state != S_DONE);
  assign mem_req    = (r_state == S_BUSY);
  assign load_valid = (r_state == S_DONE) & r_is_load;
  assign misalign   = (r_state == S_DONE) & r_misal;
  assign timeout    = (r_state == S_DONE) & r_tmo;
  assign load_data  = r_load_data;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//   Directed bench for dmem_access_ctrl (TIMEOUT_CYCLES = 4). Expected DONE
//   results are queued when an access is driven and popped when the DUT
//   releases the stall. Inputs change on the falling edge; outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_AL = 7'b0110011;

  logic        clk;
  logic        rst;
  logic        M_valid;
  logic [6:0]  M_op;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_out;
  logic [31:0] M_dm_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        timeout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .M_valid    (M_valid),
    .M_op       (M_op),
    .M_funct3   (M_funct3),
    .M_alu_out  (M_alu_out),
    .M_dm_data  (M_dm_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misalign   (misalign),
    .timeout    (timeout),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one access and follows it to DONE. delay = index of the BUSY cycle
  // in which mem_ready is raised (-1 = never).
  task automatic run_access(
    input string       tag,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] sdata,
    input logic [31:0] rdata,
    input int          delay,
    input logic        e_req,
    input logic [31:0] e_addr,
    input logic        e_we,
    input logic [3:0]  e_strb,
    input logic [31:0] e_wdata,
    input int          e_stall,
    input logic        e_lv,
    input logic [31:0] e_ld,
    input logic        e_mis,
    input logic        e_tmo
  );
    int   stalls;
    int   busy;
    logic req_seen;
    logic done;
    exp_t e;
    sb.push_back('{lv: e_lv, ld: e_ld, mis: e_mis, tmo: e_tmo});
    @(negedge clk);
    M_valid   = 1'b1;
    M_op      = op;
    M_funct3  = f3;
    M_alu_out = addr;
    M_dm_data = sdata;
    mem_rdata = rdata;
    mem_ready = 1'b0;
    #1;
    check({tag, " idle_no_pulse"}, {29'd0, load_valid, misalign, timeout}, 32'd0);
    stalls   = 0;
    busy     = 0;
    req_seen = 1'b0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (stall) begin
        stalls++;
        if (mem_req) begin
          if (!req_seen) begin
            check({tag, " mem_addr"}, mem_addr, e_addr);
            check({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, e_we});
            check({tag, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, e_strb});
            if (e_we) check({tag, " mem_wdata"}, mem_wdata, e_wdata);
          end
          req_seen  = 1'b1;
          mem_ready = (busy == delay);
          busy++;
        end else begin
          mem_ready = 1'b0;
        end
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    check({tag, " reached_done"}, {31'd0, done}, 32'd1);
    if (done) begin
      check({tag, " stall_cycles"}, stalls, e_stall);
      check({tag, " req_issued"}, {31'd0, req_seen}, {31'd0, e_req});
      check({tag, " done_no_req"}, {31'd0, mem_req}, 32'd0);
      e = sb.pop_front();
      check({tag, " load_valid"}, {31'd0, load_valid}, {31'd0, e.lv});
      if (e.lv) check({tag, " load_data"}, load_data, e.ld);
      check({tag, " misalign"}, {31'd0, misalign}, {31'd0, e.mis});
      check({tag, " timeout"}, {31'd0, timeout}, {31'd0, e.tmo});
    end
    @(negedge clk);
    M_valid   = 1'b0;
    mem_ready = 1'b0;
    #1;
    check({tag, " pulse_width"}, {29'd0, load_valid, misalign, timeout}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    M_valid   = 1'b0;
    M_op      = 7'd0;
    M_funct3  = 3'd0;
    M_alu_out = 32'd0;
    M_dm_data = 32'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst pulses", {29'd0, load_valid, misalign, timeout}, 32'd0);
    check("rst load_data", load_data, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst wstrb_we", {27'd0, mem_wstrb, mem_we}, 32'd0);
    rst = 1'b0;

    // Loads
    run_access("LW", OP_LD, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               1, 32'h100, 0, 4'b0000, 32'h0, 2, 1, 32'hDEADBEEF, 0, 0);
    run_access("LB", OP_LD, 3'b000, 32'h103, 32'h0, 32'h80123456, 1,
               1, 32'h100, 0, 4'b0000, 32'h0, 3, 1, 32'hFFFFFF80, 0, 0);
    run_access("LBU", OP_LD, 3'b100, 32'h103, 32'h0, 32'h80123456, 2,
               1, 32'h100, 0, 4'b0000, 32'h0, 4, 1, 32'h00000080, 0, 0);
    run_access("LH", OP_LD, 3'b001, 32'h102, 32'h0, 32'h80017777, 0,
               1, 32'h100, 0, 4'b0000, 32'h0, 2, 1, 32'hFFFF8001, 0, 0);
    run_access("LHU", OP_LD, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 0,
               1, 32'h100, 0, 4'b0000, 32'h0, 2, 1, 32'h0000F00D, 0, 0);
    run_access("LB_lane1", OP_LD, 3'b000, 32'h105, 32'h0, 32'h00007F00, 0,
               1, 32'h104, 0, 4'b0000, 32'h0, 2, 1, 32'h0000007F, 0, 0);
    run_access("L_f3_110", OP_LD, 3'b110, 32'h108, 32'h0, 32'hCAFEF00D, 0,
               1, 32'h108, 0, 4'b0000, 32'h0, 2, 1, 32'hCAFEF00D, 0, 0);

    // Stores
    run_access("SB", OP_ST, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0,
               1, 32'h200, 1, 4'b0010, 32'hABABABAB, 2, 0, 32'h0, 0, 0);
    run_access("SH", OP_ST, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 1,
               1, 32'h200, 1, 4'b1100, 32'hBEEFBEEF, 3, 0, 32'h0, 0, 0);
    run_access("SW", OP_ST, 3'b010, 32'h204, 32'h12345678, 32'h0, 0,
               1, 32'h204, 1, 4'b1111, 32'h12345678, 2, 0, 32'h0, 0, 0);

    // Misaligned accesses never reach memory
    run_access("LW_mis", OP_LD, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 0,
               0, 32'h0, 0, 4'b0000, 32'h0, 1, 1, 32'h0, 1, 0);
    run_access("SH_mis", OP_ST, 3'b001, 32'h201, 32'h5555, 32'h0, 0,
               0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 32'h0, 1, 0);

    // Non-memory opcode: no stall, no request
    @(negedge clk);
    M_valid = 1'b1;
    M_op    = OP_AL;
    #1;
    check("alu stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("alu mem_req", {31'd0, mem_req}, 32'd0);
    M_valid = 1'b0;

    // Timeout after 4 BUSY cycles, then a late mem_ready in IDLE is ignored
    run_access("LW_tmo", OP_LD, 3'b010, 32'h300, 32'h0, 32'h11111111, -1,
               1, 32'h300, 0, 4'b0000, 32'h0, 5, 1, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("late_ready mem_req", {31'd0, mem_req}, 32'd0);
      check("late_ready pulses", {29'd0, load_valid, misalign, timeout}, 32'd0);
    end
    mem_ready = 1'b0;

    // mem_ready in the last allowed BUSY cycle beats the timeout
    run_access("LW_last", OP_LD, 3'b010, 32'h304, 32'h0, 32'h0BADF00D, 3,
               1, 32'h304, 0, 4'b0000, 32'h0, 5, 1, 32'h0BADF00D, 0, 0);

    // Reset in BUSY cycle 2 returns everything to reset values
    @(negedge clk);
    M_valid   = 1'b1;
    M_op      = OP_LD;
    M_funct3  = 3'b010;
    M_alu_out = 32'h400;
    M_dm_data = 32'hA5A5A5A5;
    mem_ready = 1'b0;
    @(negedge clk);
    check("rstbusy req1", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    check("rstbusy req2", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstbusy mem_req", {31'd0, mem_req}, 32'd0);
    check("rstbusy mem_addr", mem_addr, 32'd0);
    check("rstbusy mem_wdata", mem_wdata, 32'd0);
    check("rstbusy wstrb_we", {27'd0, mem_wstrb, mem_we}, 32'd0);
    check("rstbusy load_data", load_data, 32'd0);
    check("rstbusy pulses", {29'd0, load_valid, misalign, timeout}, 32'd0);
    check("rstbusy stall_idle", {31'd0, stall}, 32'd1);
    rst     = 1'b0;
    M_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rstbusy no_resume", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b0;

    // Normal operation after reset
    run_access("LW_post", OP_LD, 3'b010, 32'h40C, 32'h0, 32'h76543210, 0,
               1, 32'h40C, 0, 4'b0000, 32'h0, 2, 1, 32'h76543210, 0, 0);

    check("scoreboard empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
